// File: rtl/axis_hdr_insert_multi.sv
// ============================================================================
// Module  : axis_hdr_insert_multi
// Brief   : Prepends a byte-granular multi-beat header to each AXI-Stream packet.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_hdr_insert_multi #(
  parameter int DATA_WD    = 32,
  parameter int HDR_BEATS  = 2,
  parameter int DATA_BYTES = DATA_WD / 8,
  parameter int HCNT_WD    = $clog2(HDR_BEATS * DATA_BYTES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [DATA_WD-1:0]           data_in,
  input  logic [DATA_BYTES-1:0]        keep_in,
  input  logic                         last_in,
  output logic                         ready_in,
  output logic                         valid_out,
  output logic [DATA_WD-1:0]           data_out,
  output logic [DATA_BYTES-1:0]        keep_out,
  output logic                         last_out,
  input  logic                         ready_out,
  input  logic                         valid_insert,
  input  logic [HDR_BEATS*DATA_WD-1:0] data_insert,
  input  logic [HCNT_WD-1:0]           byte_insert_cnt,
  output logic                         ready_insert
);

  localparam int          HDR_WD = HDR_BEATS * DATA_WD;
  localparam int          BC_WD  = $clog2(HDR_BEATS + 1);
  localparam int          RC_WD  = $clog2(DATA_BYTES + 1);
  localparam logic [31:0] MAX_HB = 32'(HDR_BEATS * DATA_BYTES);
  localparam logic [31:0] DB     = 32'(DATA_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [HDR_WD-1:0]     hdr_q, hdr_d;
  logic [BC_WD-1:0]      fcnt_q, fcnt_d;
  logic [RC_WD-1:0]      rcnt_q, rcnt_d;
  logic [RC_WD-1:0]      tcnt_q, tcnt_d;
  logic [DATA_WD-1:0]    res_q, res_d;
  logic                  vout_q, vout_d;
  logic [DATA_WD-1:0]    dout_q, dout_d;
  logic [DATA_BYTES-1:0] kout_q, kout_d;
  logic                  lout_q, lout_d;

  logic                  w_slot_free;
  logic [31:0]           w_hlen, w_ncnt, w_rcnt, w_tot;
  logic [HDR_WD-1:0]     w_hdr_al, w_hdr_sh;
  logic [DATA_WD-1:0]    w_din_m;

  function automatic logic [DATA_BYTES-1:0] lead_ones(input logic [31:0] n);
    lead_ones = ~({DATA_BYTES{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTES-1:0] k);
    byte_mask = '0;
    for (int i = 0; i < DATA_BYTES; i++) byte_mask[8*i +: 8] = {8{k[i]}};
  endfunction

  function automatic logic [31:0] ones(input logic [DATA_BYTES-1:0] k);
    ones = '0;
    for (int i = 0; i < DATA_BYTES; i++) ones = ones + 32'(k[i]);
  endfunction

  assign w_slot_free  = !vout_q || ready_out;
  assign ready_insert = rst_n && (state_q == S_IDLE) && w_slot_free;
  assign ready_in     = (state_q == S_DATA) && w_slot_free;

  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign keep_out  = kout_q;
  assign last_out  = lout_q;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    res_d   = res_q;
    vout_d  = vout_q;
    dout_d  = dout_q;
    kout_d  = kout_q;
    lout_d  = lout_q;

    w_hlen = 32'(byte_insert_cnt);
    if (w_hlen > MAX_HB) w_hlen = MAX_HB;
    // Left-justify the header so its first-sent byte sits at the top lane.
    w_hdr_al = data_insert << (32'd8 * (MAX_HB - w_hlen));
    w_hdr_sh = hdr_q << DATA_WD;
    w_din_m  = data_in & byte_mask(keep_in);
    w_ncnt   = ones(keep_in);
    w_rcnt   = 32'(rcnt_q);
    w_tot    = w_rcnt + w_ncnt;

    if (w_slot_free) vout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_insert && ready_insert) begin
          hdr_d   = w_hdr_al;
          fcnt_d  = BC_WD'(w_hlen / DB);
          rcnt_d  = RC_WD'(w_hlen % DB);
          res_d   = w_hdr_al[HDR_WD-1 -: DATA_WD];
          state_d = (w_hlen >= DB) ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        if (w_slot_free) begin
          vout_d = 1'b1;
          dout_d = hdr_q[HDR_WD-1 -: DATA_WD];
          kout_d = '1;
          lout_d = 1'b0;
          hdr_d  = w_hdr_sh;
          fcnt_d = fcnt_q - BC_WD'(1);
          if (fcnt_q == BC_WD'(1)) begin
            res_d   = w_hdr_sh[HDR_WD-1 -: DATA_WD];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (valid_in && ready_in) begin
          // Residual rides in front; the input's trailing R bytes carry over.
          vout_d = 1'b1;
          dout_d = res_q | (w_din_m >> (32'd8 * w_rcnt));
          res_d  = w_din_m << (32'd8 * (DB - w_rcnt));
          kout_d = '1;
          lout_d = 1'b0;
          if (last_in) begin
            if (w_tot <= DB) begin
              kout_d  = lead_ones(w_tot);
              lout_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              tcnt_d  = RC_WD'(w_tot - DB);
              state_d = S_TAIL;
            end
          end
        end
      end
      default: begin
        if (w_slot_free) begin
          vout_d  = 1'b1;
          dout_d  = res_q;
          kout_d  = lead_ones(32'(tcnt_q));
          lout_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      res_q   <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      res_q   <= res_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      lout_q  <= lout_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_hdr_insert_multi.sv
// ============================================================================
// Module  : tb_axis_hdr_insert_multi
// Brief   : Self-checking bench: directed vectors, stall/reset sequences, random packets.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_hdr_insert_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_insert, ready_insert;
  logic [63:0] data_insert;
  logic [3:0]  byte_insert_cnt;

  int chk_n  = 0;
  int fail_n = 0;
  int rdy_mode = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int              h;
    logic [63:0]     hdr;
    int              nb;
    logic [2:0][31:0] pd;
    logic [2:0][3:0]  pk;
    int              ne;
    logic [2:0][31:0] ed;
    logic [2:0][3:0]  ek;
    bit              lat;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vt[5];

  axis_hdr_insert_multi #(.DATA_WD(32), .HDR_BEATS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    chk_n++;
    if (got !== want) begin
      fail_n++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Backpressure: 0 = always ready, 1 = low 3 of every 9 cycles, 2 = random.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = ((cyc % 9) >= 3);
      default: ready_out = ($urandom_range(0, 9) < 7);
    endcase
  end

  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", 64'({valid_out, data_out, keep_out, last_out}),
            64'({1'b1, held.d, held.k, held.l}));
      if (valid_out && ready_out) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'({data_out, keep_out, last_out}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'({data_out, keep_out, last_out}), 64'({e.d, e.k, e.l}));
        end
      end else if (valid_out) begin
        stalled = 1'b1;
        held    = '{d: data_out, k: keep_out, l: last_out};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic send_pkt(input int h, input logic [63:0] hdr, input int nb,
                          input logic [7:0][31:0] pd, input logic [7:0][3:0] pk,
                          input bit gaps, input bit lat);
    int bi = 0;
    int g  = 0;
    bit hdone = 1'b0;
    bit hs_h, hs_d;
    bit idle = 1'b0;
    valid_insert    = 1'b1;
    byte_insert_cnt = 4'(h);
    data_insert     = hdr;
    while (bi < nb && g < 3000) begin
      if (idle) begin
        valid_in = 1'b0;
        last_in  = 1'b0;
      end else begin
        valid_in = 1'b1;
        data_in  = pd[bi];
        keep_in  = pk[bi];
        last_in  = (bi == nb - 1);
      end
      @(negedge clk);
      hs_h = valid_insert && ready_insert;
      hs_d = valid_in && ready_in;
      if (hs_d) begin
        chk("ready_insert_in_data", 64'(ready_insert), 64'd0);
        chk("hdr_before_payload", 64'(hdone), 64'd1);
      end
      @(posedge clk);
      #1;
      g++;
      idle = 1'b0;
      if (hs_h) begin
        hdone        = 1'b1;
        valid_insert = 1'b0;
      end
      if (hs_d) begin
        if (lat)
          chk("latency", 64'({valid_out, data_out, keep_out}), 64'({1'b1, pd[bi], pk[bi]}));
        bi++;
        if (gaps && $urandom_range(0, 3) == 0) idle = 1'b1;
      end
    end
    valid_in     = 1'b0;
    last_in      = 1'b0;
    valid_insert = 1'b0;
    if (g >= 3000) chk("send_timeout", 64'(bi), 64'(nb));
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_vec(input int i);
    logic [7:0][31:0] pd8;
    logic [7:0][3:0]  pk8;
    pd8 = '0;
    pk8 = '0;
    for (int j = 0; j < vt[i].nb; j++) begin
      pd8[j] = vt[i].pd[j];
      pk8[j] = vt[i].pk[j];
    end
    for (int j = 0; j < vt[i].ne; j++)
      exp_q.push_back('{d: vt[i].ed[j], k: vt[i].ek[j], l: (j == vt[i].ne - 1)});
    send_pkt(vt[i].h, vt[i].hdr, vt[i].nb, pd8, pk8, 1'b0, vt[i].lat);
    wait_drain();
  endtask

  // Reference: concatenate header and payload bytes, then re-chunk into beats.
  task automatic model_pkt(input int h, input logic [63:0] hdr, input int nb,
                           input logic [7:0][31:0] pd, input int nlast);
    logic [7:0] bq[$];
    int hc;
    int nbytes;
    beat_t b;
    hc = (h > 8) ? 8 : h;
    for (int k = hc - 1; k >= 0; k--) bq.push_back(hdr[8*k +: 8]);
    for (int i = 0; i < nb; i++) begin
      nbytes = (i == nb - 1) ? nlast : 4;
      for (int j = 0; j < nbytes; j++) bq.push_back(pd[i][31-8*j -: 8]);
    end
    while (bq.size() > 0) begin
      b = '0;
      for (int j = 0; j < 4; j++) begin
        if (bq.size() > 0) begin
          b.d[31-8*j -: 8] = bq.pop_front();
          b.k[3-j]         = 1'b1;
        end
      end
      b.l = (bq.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    fail_n++;
    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
    $fatal(1);
  end

  initial begin
    int g;
    bit hs;
    logic [7:0][31:0] pd8;
    logic [7:0][3:0]  pk8;
    int h, nb, nl;
    logic [3:0] km;
    logic [63:0] hdr;

    // Packed pairs below: element 0 is the rightmost entry.
    vt[0] = '{h: 3, hdr: 64'h00AABBCC, nb: 2,
              pd: {32'h0, 32'h55660000, 32'h11223344}, pk: {4'h0, 4'b1100, 4'b1111},
              ne: 3, ed: {32'h66000000, 32'h22334455, 32'hAABBCC11},
              ek: {4'b1000, 4'b1111, 4'b1111}, lat: 1'b0};
    vt[1] = '{h: 4, hdr: 64'hDDEEFF00, nb: 2,
              pd: {32'h0, 32'h55660000, 32'h11223344}, pk: {4'h0, 4'b1100, 4'b1111},
              ne: 3, ed: {32'h55660000, 32'h11223344, 32'hDDEEFF00},
              ek: {4'b1100, 4'b1111, 4'b1111}, lat: 1'b0};
    vt[2] = '{h: 6, hdr: 64'h0000112233445566, nb: 1,
              pd: {32'h0, 32'h0, 32'hA0A1A2A3}, pk: {4'h0, 4'h0, 4'b1111},
              ne: 3, ed: {32'hA2A30000, 32'h5566A0A1, 32'h11223344},
              ek: {4'b1100, 4'b1111, 4'b1111}, lat: 1'b0};
    vt[3] = '{h: 0, hdr: 64'hFFFFFFFFFFFFFFFF, nb: 3,
              pd: {32'h090A0B00, 32'h05060708, 32'h01020304}, pk: {4'b1110, 4'b1111, 4'b1111},
              ne: 3, ed: {32'h090A0B00, 32'h05060708, 32'h01020304},
              ek: {4'b1110, 4'b1111, 4'b1111}, lat: 1'b1};
    vt[4] = '{h: 9, hdr: 64'h1122334455667788, nb: 1,
              pd: {32'h0, 32'h0, 32'hCAFEBABE}, pk: {4'h0, 4'h0, 4'b1000},
              ne: 3, ed: {32'hCA000000, 32'h55667788, 32'h11223344},
              ek: {4'b1000, 4'b1111, 4'b1111}, lat: 1'b0};

    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; byte_insert_cnt = '0;
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_data_keep_last", 64'({data_out, keep_out, last_out}), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_ready_insert", 64'(ready_insert), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_insert", 64'(ready_insert), 64'd1);
    chk("idle_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_vec(i);

    rdy_mode = 1;
    repeat (3) run_vec(0);
    rdy_mode = 0;

    // Reset during DATA of the H=6 case: only the first header beat gets out.
    valid_insert = 1'b1; byte_insert_cnt = 4'd6; data_insert = 64'h0000112233445566;
    g = 0;
    do begin
      @(negedge clk);
      hs = ready_insert;
      @(posedge clk);
      #1;
      g++;
    end while (!hs && g < 50);
    valid_insert = 1'b0;
    chk("reset_seq_hdr_taken", 64'(hs), 64'd1);
    @(posedge clk);
    #3;
    chk("reset_seq_hdr_beat", 64'({valid_out, data_out}), 64'({1'b1, 32'h11223344}));
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_data_keep_last", 64'({data_out, keep_out, last_out}), 64'd0);
    chk("midrst_readies", 64'({ready_in, ready_insert}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(0);

    // Randomized packets under random backpressure and source gaps.
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      h   = int'($urandom_range(0, 10));
      hdr = {$urandom, $urandom};
      nb  = int'($urandom_range(1, 6));
      nl  = int'($urandom_range(1, 4));
      pd8 = '0;
      pk8 = '0;
      for (int i = 0; i < nb; i++) begin
        pd8[i] = $urandom;
        pk8[i] = 4'b1111;
      end
      km = 4'b1111;
      km = km << (4 - nl);
      pk8[nb-1] = km;
      model_pkt(h, hdr, nb, pd8, nl);
      send_pkt(h, hdr, nb, pd8, pk8, 1'b1, 1'b0);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", chk_n, fail_n);
    $finish;
  end

endmodule

`default_nettype wire
